// File: rtl/astra_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : astra_march_bist
// Purpose  : March-test BIST controller for a small N-word RAM. When start
//            is seen high in idle, it takes over the RAM pins and runs a
//            fixed six-element march, one RAM operation per clock:
//            E0 up w0, E1 up r0, E2 up w1, E3 down r1, E4 down w0,
//            E5 down r0.
//            Each read is checked against its expected background word on
//            the clock edge that ends the read cycle. The first mismatch
//            aborts the run with SUCCESS=0. A clean finish sets SUCCESS=1.
// Ports    : clk      - system clock; all state changes on the rising edge
//            rst_n    - asynchronous active-low reset
//            start    - run request, sampled only while idle
//            MARCHING - high while the BIST owns the RAM pins
//            SUCCESS  - result of the last completed run (1 = pass)
//            ADDRESS  - RAM address
//            DATA     - RAM write data
//            OUT      - RAM read data
//            CS/WE/OE - RAM chip select, write enable, output enable
// Revision : 1.0 - initial release
// ============================================================================
module astra_march_bist #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              MARCHING,
    output logic              SUCCESS,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] DATA,
    input  logic [DATA_W-1:0] OUT,
    output logic              CS,
    output logic              WE,
    output logic              OE
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] ELEM_LAST = 3'd5;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              success_q, success_d;

    // Element decode:
    // - Odd elements (E1, E3, E5) are reads.
    // - E3 to E5 walk the addresses downward.
    // - E2 and E3 use the all-ones background.
    logic              w_is_read;
    logic              w_down;
    logic [DATA_W-1:0] w_pattern;
    logic              w_elem_end;
    logic              w_read_fail;
    logic [2:0]        w_elem_inc;

    always_comb begin
        w_is_read   = elem_q[0];
        w_down      = (elem_q >= 3'd3);
        w_pattern   = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
        w_elem_end  = w_down ? (addr_q == '0) : (addr_q == '1);
        w_read_fail = w_is_read && (OUT != w_pattern);
        w_elem_inc  = elem_q + 3'd1;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        success_d = success_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    elem_d    = 3'd0;
                    addr_d    = '0;
                    success_d = 1'b0;
                end
            end
            S_RUN: begin
                if (w_read_fail) begin
                    // Abort. SUCCESS was already cleared at the start edge.
                    state_d = S_IDLE;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                end else if (w_elem_end) begin
                    if (elem_q == ELEM_LAST) begin
                        state_d   = S_IDLE;
                        success_d = 1'b1;
                        elem_d    = 3'd0;
                        addr_d    = '0;
                    end else begin
                        elem_d = w_elem_inc;
                        // Downward elements (E3 onward) restart at N-1.
                        // Upward elements restart at 0.
                        addr_d = (w_elem_inc >= 3'd3) ? '1 : '0;
                    end
                end else begin
                    addr_d = w_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                elem_d  = 3'd0;
                addr_d  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            elem_q    <= 3'd0;
            addr_q    <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            addr_q    <= addr_d;
            success_q <= success_d;
        end
    end

    // RAM pin outputs. They are decoded from registered state only,
    // so an asynchronous reset forces them low at once.
    always_comb begin
        MARCHING = 1'b0;
        SUCCESS  = success_q;
        ADDRESS  = '0;
        DATA     = '0;
        CS       = 1'b0;
        WE       = 1'b0;
        OE       = 1'b0;
        if (state_q == S_RUN) begin
            MARCHING = 1'b1;
            ADDRESS  = addr_q;
            CS       = 1'b1;
            WE       = !w_is_read;
            OE       = w_is_read;
            DATA     = w_is_read ? '0 : w_pattern;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_astra_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_astra_march_bist
// Purpose  : Self-checking bench for astra_march_bist. It drives a
//            behavioural 4x3 RAM with an optional fault: bit0 of
//            address 2 stuck-at-1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_astra_march_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       MARCHING;
    logic       SUCCESS;
    logic [1:0] ADDRESS;
    logic [2:0] DATA;
    logic [2:0] OUT;
    logic       CS;
    logic       WE;
    logic       OE;

    int checks;
    int errors;

    logic [2:0] mem [4];
    logic       fault_en;

    // Hand-computed expected sequences
    int         exp_addr [24] = '{0,1,2,3, 0,1,2,3, 0,1,2,3,
                                  3,2,1,0, 3,2,1,0, 3,2,1,0};
    logic       exp_we   [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_data [6]  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};

    astra_march_bist #(.ADDR_W(2), .DATA_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MARCHING (MARCHING),
        .SUCCESS  (SUCCESS),
        .ADDRESS  (ADDRESS),
        .DATA     (DATA),
        .OUT      (OUT),
        .CS       (CS),
        .WE       (WE),
        .OE       (OE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read
    always @(posedge clk) begin
        if (CS && WE) mem[ADDRESS] <= DATA;
    end

    always_comb begin
        OUT = 3'b000;
        if (CS && OE) begin
            OUT = mem[ADDRESS];
            if (fault_en && ADDRESS == 2'd2) OUT[0] = 1'b1;
        end
    end

    // Stimulus helper: pulse start across exactly one rising edge.
    // It returns shortly after that edge, so the next negedge is in cycle 0.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS, ADDRESS, DATA, CS, WE, OE} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {MARCHING, SUCCESS, ADDRESS, DATA, CS, WE, OE}, 10'b0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS, CS} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000", {MARCHING, SUCCESS, CS});
        end
    endtask

    task automatic test_full_run();
        logic [8:0] exp_v;
        int e;
        do_start();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            e = k / 4;
            // Vector layout: {MARCHING, ADDRESS, CS, WE, OE, DATA}
            exp_v = {1'b1, 2'(exp_addr[k]), 1'b1, exp_we[e], !exp_we[e], exp_data[e]};
            checks++;
            if ({MARCHING, ADDRESS, CS, WE, OE, DATA} !== exp_v) begin
                errors++;
                $display("FAIL full_run_cycle%0d: got %b expected %b",
                         k, {MARCHING, ADDRESS, CS, WE, OE, DATA}, exp_v);
            end
            if (k == 0) begin
                checks++;
                if (SUCCESS !== 1'b0) begin
                    errors++;
                    $display("FAIL full_run_success_cleared: got %b expected 0", SUCCESS);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS, CS} !== 3'b010) begin
            errors++;
            $display("FAIL full_run_done: got %b expected 010", {MARCHING, SUCCESS, CS});
        end
    endtask

    task automatic test_stuck_fault();
        int cs_count;
        fault_en = 1'b1;
        do_start();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (MARCHING !== 1'b1 || ADDRESS !== 2'(exp_addr[k])) begin
                errors++;
                $display("FAIL fault_pre_abort_cycle%0d: got M=%b A=%0d expected M=1 A=%0d",
                         k, MARCHING, ADDRESS, exp_addr[k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS} !== 2'b00) begin
            errors++;
            $display("FAIL fault_abort: got %b expected 00", {MARCHING, SUCCESS});
        end
        cs_count = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (CS) cs_count++;
        end
        checks++;
        if (cs_count !== 0) begin
            errors++;
            $display("FAIL fault_no_more_access: got %0d CS cycles expected 0", cs_count);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_start();
        for (int k = 0; k <= 10; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({MARCHING, SUCCESS, ADDRESS, DATA, CS, WE, OE} !== 10'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected %b",
                     {MARCHING, SUCCESS, ADDRESS, DATA, CS, WE, OE}, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if (MARCHING !== 1'b1 || ADDRESS !== 2'(exp_addr[k])) begin
                errors++;
                $display("FAIL rerun_after_reset_cycle%0d: got M=%b A=%0d expected M=1 A=%0d",
                         k, MARCHING, ADDRESS, exp_addr[k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS} !== 2'b01) begin
            errors++;
            $display("FAIL rerun_after_reset_done: got %b expected 01", {MARCHING, SUCCESS});
        end
    endtask

    task automatic test_start_ignored();
        do_start();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if (MARCHING !== 1'b1 || ADDRESS !== 2'(exp_addr[k])) begin
                errors++;
                $display("FAIL start_ignored_cycle%0d: got M=%b A=%0d expected M=1 A=%0d",
                         k, MARCHING, ADDRESS, exp_addr[k]);
            end
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS} !== 2'b01) begin
            errors++;
            $display("FAIL start_ignored_done: got %b expected 01", {MARCHING, SUCCESS});
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (SUCCESS !== 1'b1) begin
            errors++;
            $display("FAIL b2b_before: got %b expected 1", SUCCESS);
        end
        do_start();
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_start_clears: got %b expected 10", {MARCHING, SUCCESS});
        end
        for (int k = 1; k < 24; k++) @(negedge clk);
        checks++;
        if (MARCHING !== 1'b1 || ADDRESS !== 2'd0) begin
            errors++;
            $display("FAIL b2b_last_cycle: got M=%b A=%0d expected M=1 A=0", MARCHING, ADDRESS);
        end
        @(negedge clk);
        checks++;
        if ({MARCHING, SUCCESS} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 01", {MARCHING, SUCCESS});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        start    = 1'b0;
        fault_en = 1'b0;
        rst_n    = 1'b0;
        // word_gen-style preload; the march overwrites it in E0
        mem[0] = 3'b101;
        mem[1] = 3'b010;
        mem[2] = 3'b111;
        mem[3] = 3'b001;
        test_reset();
        test_full_run();
        test_stuck_fault();
        test_reset_mid_run();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
